// File: rtl/axi_multi_chan_logger_if.sv
// Observation bus for axi_multi_chan_logger: NUM_CHAN AXI address channels,
// packed per channel (channel c at [c*W +: W]).
// master = side that drives the channels, slave = the logger (monitor only).
interface axi_multi_chan_logger_if #(
   parameter int NUM_CHAN      = 2,
   parameter int AXI_ADDR_BITW = 32,
   parameter int AXI_ID_BITW   = 8,
   parameter int AXI_LEN_BITW  = 8
);
   logic [NUM_CHAN-1:0]               AxiValid_SI;
   logic [NUM_CHAN-1:0]               AxiReady_SI;
   logic [NUM_CHAN*AXI_ID_BITW-1:0]   AxiId_DI;
   logic [NUM_CHAN*AXI_ADDR_BITW-1:0] AxiAddr_DI;
   logic [NUM_CHAN*AXI_LEN_BITW-1:0]  AxiLen_DI;

   modport master (output AxiValid_SI, AxiReady_SI, AxiId_DI, AxiAddr_DI, AxiLen_DI);
   modport slave  (input  AxiValid_SI, AxiReady_SI, AxiId_DI, AxiAddr_DI, AxiLen_DI);
endinterface

// File: rtl/axi_multi_chan_logger.sv
// Multi-channel AXI address-beat logger. Handshaken beats are timestamped,
// queued in per-channel FIFOs, picked round-robin (one per cycle) and written
// as records {ts, addr, len, id, chan} (chan at LSB) to an external log RAM.
// Stop-on-full or ring-buffer mode; sticky Wrapped/Overflow status.
// Optional: define LOGGER_DROP_CNT_EN to add the saturating DropCnt_DO counter.
module axi_multi_chan_logger #(
   parameter int NUM_CHAN       = 2,
   parameter int AXI_ADDR_BITW  = 32,
   parameter int AXI_ID_BITW    = 8,
   parameter int AXI_LEN_BITW   = 8,
   parameter int TS_BITW        = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int LOG_DEPTH      = 4096,
   localparam int CHAN_BITW     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
   localparam int REC_BITW      = CHAN_BITW + AXI_ID_BITW + AXI_LEN_BITW + AXI_ADDR_BITW + TS_BITW,
   localparam int MEM_DATA_BITW = 32 * ((REC_BITW + 31) / 32),
   localparam int MEM_ADDR_BITW = $clog2(LOG_DEPTH)
) (
   input  logic                       Clk_CI,
   input  logic                       Rst_RI,
   axi_multi_chan_logger_if.slave     axi_bus,
   input  logic                       Enable_SI,
   input  logic                       Clear_SI,
   input  logic                       WrapMode_SI,
   output logic                       MemWrEn_SO,
   output logic [MEM_ADDR_BITW-1:0]   MemAddr_DO,
   output logic [MEM_DATA_BITW-1:0]   MemWrData_DO,
   output logic                       Full_SO,
   output logic                       Wrapped_SO,
   output logic                       Overflow_SO,
   output logic [MEM_ADDR_BITW:0]     Count_DO
`ifdef LOGGER_DROP_CNT_EN
   ,
   output logic [15:0]                DropCnt_DO
`endif
);
   localparam int ENT_BITW  = REC_BITW - CHAN_BITW;   // record without the channel index
   localparam int FPTR_BITW = $clog2(FIFO_DEPTH) + 1; // extra MSB distinguishes full/empty
   localparam logic [MEM_ADDR_BITW-1:0] LAST_ADDR = MEM_ADDR_BITW'(LOG_DEPTH - 1);
   localparam logic [MEM_ADDR_BITW:0]   COUNT_MAX = (MEM_ADDR_BITW + 1)'(LOG_DEPTH);

   typedef enum logic [1:0] {STOPPED, RUN, FULL} state_t;
   state_t state_reg, state_next;

   logic [TS_BITW-1:0]       ts_reg;
   logic [NUM_CHAN-1:0]      hs, capture, drop, push, pop, fifo_empty, fifo_full;
   logic [ENT_BITW-1:0]      entry [NUM_CHAN];
   logic [ENT_BITW-1:0]      head  [NUM_CHAN];
   logic [CHAN_BITW-1:0]     rr_reg, grant_idx;
   logic                     grant_valid, pop_en, accept_ok, last_write;
   logic                     wr_valid_reg, wrapped_reg, overflow_reg;
   logic [MEM_ADDR_BITW-1:0] wr_ptr_reg, wr_addr_reg;
   logic [MEM_DATA_BITW-1:0] wr_data_reg;
   logic [MEM_ADDR_BITW:0]   count_reg;

   assign accept_ok  = Enable_SI & ~Clear_SI;
   assign hs         = axi_bus.AxiValid_SI & axi_bus.AxiReady_SI;
   assign capture    = (accept_ok && state_reg != FULL) ? hs : '0;
   // In FULL every handshake is lost; otherwise only those hitting a full FIFO
   assign drop       = accept_ok ? ((state_reg == FULL) ? hs : (hs & fifo_full)) : '0;
   assign push       = capture & ~fifo_full;
   assign last_write = wr_valid_reg && (wr_addr_reg == LAST_ADDR);
   // In stop mode nothing may be popped while the final slot is being written,
   // otherwise a record would be assigned to a wrapped address.
   assign pop_en     = grant_valid & ~Clear_SI & (state_reg != FULL) & ~(last_write & ~WrapMode_SI);

   for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
      logic [ENT_BITW-1:0]  mem_reg [FIFO_DEPTH];
      logic [FPTR_BITW-1:0] wptr_reg, rptr_reg;

      assign entry[gi] = {ts_reg,
                          axi_bus.AxiAddr_DI[gi*AXI_ADDR_BITW +: AXI_ADDR_BITW],
                          axi_bus.AxiLen_DI[gi*AXI_LEN_BITW +: AXI_LEN_BITW],
                          axi_bus.AxiId_DI[gi*AXI_ID_BITW +: AXI_ID_BITW]};
      assign fifo_empty[gi] = (wptr_reg == rptr_reg);
      assign fifo_full[gi]  = (wptr_reg[FPTR_BITW-1] != rptr_reg[FPTR_BITW-1]) &&
                              (wptr_reg[FPTR_BITW-2:0] == rptr_reg[FPTR_BITW-2:0]);
      assign head[gi]       = mem_reg[rptr_reg[FPTR_BITW-2:0]];
      assign pop[gi]        = pop_en && (grant_idx == CHAN_BITW'(gi));

      // FIFO storage, no reset needed (validity tracked by pointers)
      always_ff @(posedge Clk_CI) begin
         if (push[gi]) mem_reg[wptr_reg[FPTR_BITW-2:0]] <= entry[gi];
      end

      // FIFO pointers; clear flushes
      always_ff @(posedge Clk_CI or posedge Rst_RI) begin
         if (Rst_RI) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
         end else if (Clear_SI) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
         end else begin
            if (push[gi]) wptr_reg <= wptr_reg + 1'b1;
            if (pop[gi])  rptr_reg <= rptr_reg + 1'b1;
         end
      end
   end

   // Round-robin search: first non-empty FIFO at or after the RR pointer
   always_comb begin
      logic [CHAN_BITW:0] cand;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         cand = {1'b0, rr_reg} + (CHAN_BITW + 1)'(i);
         if (cand >= (CHAN_BITW + 1)'(NUM_CHAN)) cand = cand - (CHAN_BITW + 1)'(NUM_CHAN);
         if (!fifo_empty[cand[CHAN_BITW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[CHAN_BITW-1:0];
         end
      end
   end

   // Next-state logic for the capture/stop FSM
   always_comb begin
      state_next = state_reg;
      if (Clear_SI) begin
         state_next = Enable_SI ? RUN : STOPPED;
      end else begin
         case (state_reg)
            STOPPED: if (last_write && !WrapMode_SI) state_next = FULL;
                     else if (Enable_SI)             state_next = RUN;
            RUN:     if (last_write && !WrapMode_SI) state_next = FULL;
                     else if (!Enable_SI)            state_next = STOPPED;
            default: state_next = FULL;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) state_reg <= STOPPED;
      else        state_reg <= state_next;
   end

   // Timestamp, RR pointer, write stage and status registers
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         ts_reg       <= '0;
         rr_reg       <= '0;
         wr_valid_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
         count_reg    <= '0;
         wrapped_reg  <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (Clear_SI) begin
         ts_reg       <= '0;
         rr_reg       <= '0;
         wr_valid_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         wr_addr_reg  <= '0;
         count_reg    <= '0;
         wrapped_reg  <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         ts_reg       <= ts_reg + 1'b1;
         wr_valid_reg <= pop_en;
         if (pop_en) begin
            rr_reg      <= (grant_idx == CHAN_BITW'(NUM_CHAN - 1)) ? '0 : grant_idx + 1'b1;
            wr_addr_reg <= wr_ptr_reg;
            wr_data_reg <= MEM_DATA_BITW'({head[grant_idx], grant_idx});
            wr_ptr_reg  <= wr_ptr_reg + 1'b1;
         end
         if (wr_valid_reg && count_reg != COUNT_MAX) count_reg <= count_reg + 1'b1;
         if (last_write && WrapMode_SI) wrapped_reg <= 1'b1;
         if (|drop) overflow_reg <= 1'b1;
      end
   end

`ifdef LOGGER_DROP_CNT_EN
   logic [15:0] drop_cnt_reg;
   logic [16:0] drop_sum;

   // Add this cycle's drops (several channels may drop at once)
   always_comb begin
      drop_sum = {1'b0, drop_cnt_reg};
      for (int i = 0; i < NUM_CHAN; i++) drop_sum = drop_sum + 17'(drop[i]);
   end

   // Saturating drop counter
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI)        drop_cnt_reg <= '0;
      else if (Clear_SI) drop_cnt_reg <= '0;
      else               drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   assign DropCnt_DO = drop_cnt_reg;
`endif

   assign MemWrEn_SO   = wr_valid_reg;
   assign MemAddr_DO   = wr_addr_reg;
   assign MemWrData_DO = wr_data_reg;
   assign Full_SO      = (state_reg == FULL);
   assign Wrapped_SO   = wrapped_reg;
   assign Overflow_SO  = overflow_reg;
   assign Count_DO     = count_reg;
endmodule

// File: tb/tb_axi_multi_chan_logger.sv
// Directed bench for axi_multi_chan_logger: table of single beats, then
// hand-written sequences for simultaneous beats, stop-on-full, wrap,
// overflow and clear-mid-burst. Small log (16 records) to reach boundaries.
module tb_axi_multi_chan_logger;
   localparam int NC  = 2;
   localparam int FD  = 4;
   localparam int LD  = 16;
   localparam int MAW = 4;
   localparam int MDW = 96;   // 1+8+8+32+32 = 81 bits rounded up to 3 words

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, wrap = 1'b0;
   logic           mem_wr_en;
   logic [MAW-1:0] mem_addr;
   logic [MDW-1:0] mem_data;
   logic           full, wrapped, overflow;
   logic [MAW:0]   count;
`ifdef LOGGER_DROP_CNT_EN
   logic [15:0]    drop_cnt;
`endif

   int          checks = 0, errors = 0, cyc = 0;
   logic [31:0] ts_model;

   typedef struct {
      int             cyc;
      logic [MAW-1:0] addr;
      logic [MDW-1:0] data;
   } wr_t;
   wr_t wq[$];

   typedef struct {
      int          ch;
      logic [7:0]  id;
      logic [7:0]  len;
      logic [31:0] addr;
      int          exp_addr;
   } vec_t;
   vec_t vecs[5];

   axi_multi_chan_logger_if #(.NUM_CHAN(NC), .AXI_ADDR_BITW(32), .AXI_ID_BITW(8), .AXI_LEN_BITW(8)) bus ();

   axi_multi_chan_logger #(
      .NUM_CHAN(NC), .AXI_ADDR_BITW(32), .AXI_ID_BITW(8), .AXI_LEN_BITW(8),
      .TS_BITW(32), .FIFO_DEPTH(FD), .LOG_DEPTH(LD)
   ) dut (
      .Clk_CI(clk), .Rst_RI(rst), .axi_bus(bus),
      .Enable_SI(en), .Clear_SI(clr), .WrapMode_SI(wrap),
      .MemWrEn_SO(mem_wr_en), .MemAddr_DO(mem_addr), .MemWrData_DO(mem_data),
      .Full_SO(full), .Wrapped_SO(wrapped), .Overflow_SO(overflow), .Count_DO(count)
`ifdef LOGGER_DROP_CNT_EN
      , .DropCnt_DO(drop_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected timestamp: cycles since reset/clear
   always @(posedge clk or posedge rst) begin
      if (rst)      ts_model <= 0;
      else if (clr) ts_model <= 0;
      else          ts_model <= ts_model + 1;
   end

   // Record every log RAM write, one line per transaction
   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) begin
         wq.push_back('{cyc, mem_addr, mem_data});
         $display("write cyc=%0d addr=%0d data=%h", cyc, mem_addr, mem_data);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [MDW-1:0] mk_rec(input logic ch, input logic [7:0] id, input logic [7:0] len,
                                             input logic [31:0] addr, input logic [31:0] ts);
      logic [80:0] r;
      r = {ts, addr, len, id, ch};
      return {15'b0, r};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ch(input int ch, input logic v, input logic [7:0] id, input logic [7:0] len,
                         input logic [31:0] addr);
      bus.AxiValid_SI[ch]      = v;
      bus.AxiReady_SI[ch]      = v;
      bus.AxiId_DI[ch*8 +: 8]   = id;
      bus.AxiLen_DI[ch*8 +: 8]  = len;
      bus.AxiAddr_DI[ch*32 +: 32] = addr;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
      wq.delete();
   endtask

   task automatic wait_writes(input string nm, input int n, input int budget);
      int k = 0;
      while (wq.size() < n && k < budget) begin
         step();
         k++;
      end
      check({nm, "_timeout"}, 128'(wq.size() >= n), 128'(1));
   endtask

   task automatic chk_wr(input string nm, input int i, input int exp_addr, input logic [MDW-1:0] exp_data,
                         input bit use_data);
      if (i >= wq.size()) begin
         check({nm, "_missing"}, 128'(wq.size()), 128'(i + 1));
         return;
      end
      check({nm, "_addr"}, 128'(wq[i].addr), 128'(exp_addr));
      if (use_data) check({nm, "_data"}, 128'(wq[i].data), 128'(exp_data));
   endtask

   initial begin
      logic [31:0] ts0;
      int          k0, n;

      vecs[0] = '{0, 8'h5A, 8'h03, 32'h1000_0040, 0};
      vecs[1] = '{1, 8'hA5, 8'hFF, 32'hFFFF_FFFC, 1};
      vecs[2] = '{0, 8'h00, 8'h00, 32'h0000_0000, 2};
      vecs[3] = '{1, 8'hFF, 8'h80, 32'h8000_0001, 3};
      vecs[4] = '{1, 8'h3C, 8'h0F, 32'hDEAD_BEE0, 4};

      bus.AxiValid_SI = '0;
      bus.AxiReady_SI = '0;
      bus.AxiId_DI    = '0;
      bus.AxiLen_DI   = '0;
      bus.AxiAddr_DI  = '0;

      // ---- reset state ----
      step(3);
      check("rst_wren", 128'(mem_wr_en), 0);
      check("rst_addr", 128'(mem_addr), 0);
      check("rst_data", 128'(mem_data), 0);
      check("rst_full", 128'(full), 0);
      check("rst_wrapped", 128'(wrapped), 0);
      check("rst_overflow", 128'(overflow), 0);
      check("rst_count", 128'(count), 0);
      rst = 1'b0;
      en  = 1'b1;
      wrap = 1'b0;
      do_clear();

      // ---- table of single beats; first one at timestamp 10 ----
      for (int g = 0; g < 50 && ts_model != 10; g++) step();
      for (int i = 0; i < 5; i++) begin
         k0  = cyc;
         ts0 = ts_model;
         set_ch(vecs[i].ch, 1'b1, vecs[i].id, vecs[i].len, vecs[i].addr);
         step();
         set_ch(vecs[i].ch, 1'b0, 8'h0, 8'h0, 32'h0);
         wait_writes($sformatf("vec%0d", i), i + 1, 10);
         chk_wr($sformatf("vec%0d", i), i, vecs[i].exp_addr,
                mk_rec(vecs[i].ch[0], vecs[i].id, vecs[i].len, vecs[i].addr, ts0), 1'b1);
         if (i < wq.size()) check($sformatf("vec%0d_latency", i), 128'(wq[i].cyc - k0), 128'(2));
         check($sformatf("vec%0d_count", i), 128'(count), 128'(i + 1));
      end
      if (wq.size() > 0) check("vec0_ts10", 128'(wq[0].data[80:49]), 128'(10));

      // ---- simultaneous beats on both channels, twice (RR pointer back at 0) ----
      do_clear();
      for (int r = 0; r < 2; r++) begin
         ts0 = ts_model;
         set_ch(0, 1'b1, 8'h11, 8'h01, 32'h0000_1000);
         set_ch(1, 1'b1, 8'h22, 8'h02, 32'h0000_2000);
         step();
         set_ch(0, 1'b0, 8'h0, 8'h0, 32'h0);
         set_ch(1, 1'b0, 8'h0, 8'h0, 32'h0);
         wait_writes($sformatf("sim%0d", r), 2 * r + 2, 10);
         chk_wr($sformatf("sim%0d_ch0", r), 2 * r, 2 * r, mk_rec(1'b0, 8'h11, 8'h01, 32'h0000_1000, ts0), 1'b1);
         chk_wr($sformatf("sim%0d_ch1", r), 2 * r + 1, 2 * r + 1, mk_rec(1'b1, 8'h22, 8'h02, 32'h0000_2000, ts0), 1'b1);
      end

      // ---- stop on full: 20 beats, only 16 written ----
      wrap = 1'b0;
      do_clear();
      for (int i = 0; i < 20; i++) begin
         set_ch(0, 1'b1, 8'(i), 8'h00, 32'h4000_0000 + 32'(i));
         step();
      end
      set_ch(0, 1'b0, 8'h0, 8'h0, 32'h0);
      wait_writes("full", 16, 40);
      step(10);
      check("full_nwrites", 128'(wq.size()), 128'(16));
      for (int i = 0; i < 16; i++) chk_wr($sformatf("full_w%0d", i), i, i, '0, 1'b0);
      if (wq.size() > 15) check("full_last_id", 128'(wq[15].data[8:1]), 128'(15));
      check("full_flag", 128'(full), 1);
      check("full_count", 128'(count), 128'(16));
      check("full_overflow", 128'(overflow), 1);
      check("full_wren_after", 128'(mem_wr_en), 0);

      // ---- wrap mode: 20 beats, addresses 0..15 then 0..3 ----
      wrap = 1'b1;
      do_clear();
      check("clr_full", 128'(full), 0);
      for (int i = 0; i < 20; i++) begin
         set_ch(0, 1'b1, 8'(i), 8'h00, 32'h5000_0000);
         step();
      end
      set_ch(0, 1'b0, 8'h0, 8'h0, 32'h0);
      wait_writes("wrap", 20, 40);
      step(5);
      check("wrap_nwrites", 128'(wq.size()), 128'(20));
      for (int i = 14; i < 20; i++) chk_wr($sformatf("wrap_w%0d", i), i, i % 16, '0, 1'b0);
      check("wrap_wrapped", 128'(wrapped), 1);
      check("wrap_full", 128'(full), 0);
      check("wrap_count", 128'(count), 128'(16));
      check("wrap_overflow", 128'(overflow), 0);

      // ---- overflow: both channels every cycle for 12 cycles ----
      do_clear();
      for (int i = 0; i < 12; i++) begin
         set_ch(0, 1'b1, 8'(i), 8'h00, 32'h6000_0000);
         set_ch(1, 1'b1, 8'(i + 8'h80), 8'h00, 32'h7000_0000);
         step();
      end
      set_ch(0, 1'b0, 8'h0, 8'h0, 32'h0);
      set_ch(1, 1'b0, 8'h0, 8'h0, 32'h0);
      wait_writes("ovf", 18, 40);
      step(10);
      check("ovf_nwrites", 128'(wq.size()), 128'(18));
      check("ovf_overflow", 128'(overflow), 1);
      check("ovf_count_sat", 128'(count), 128'(16));
      check("ovf_wrapped", 128'(wrapped), 1);
`ifdef LOGGER_DROP_CNT_EN
      check("ovf_dropcnt", 128'(drop_cnt), 128'(24 - 18));
`endif

      // ---- clear asserted in the cycle after a pop ----
      wq.delete();
      set_ch(0, 1'b1, 8'h01, 8'h00, 32'h9000_0000);
      step();                    // beat 1 captured
      set_ch(0, 1'b1, 8'h02, 8'h00, 32'h9000_0004);
      step();                    // beat 1 popped, beat 2 captured
      set_ch(0, 1'b1, 8'h03, 8'h00, 32'h9000_0008);
      clr = 1'b1;
      step();                    // clear cycle
      clr = 1'b0;
      set_ch(0, 1'b0, 8'h0, 8'h0, 32'h0);
      check("clrmid_wren", 128'(mem_wr_en), 0);
      check("clrmid_addr", 128'(mem_addr), 0);
      check("clrmid_count", 128'(count), 0);
      check("clrmid_full", 128'(full), 0);
      check("clrmid_wrapped", 128'(wrapped), 0);
      check("clrmid_overflow", 128'(overflow), 0);
`ifdef LOGGER_DROP_CNT_EN
      check("clrmid_dropcnt", 128'(drop_cnt), 0);
`endif
      wq.delete();
      step(3);
      ts0 = ts_model;
      set_ch(0, 1'b1, 8'h77, 8'h07, 32'hABCD_0000);
      step();
      set_ch(0, 1'b0, 8'h0, 8'h0, 32'h0);
      wait_writes("after_clr", 1, 10);
      step(5);
      chk_wr("after_clr", 0, 0, mk_rec(1'b0, 8'h77, 8'h07, 32'hABCD_0000, ts0), 1'b1);
      if (wq.size() > 0) check("after_clr_ts", 128'(wq[0].data[80:49]), 128'(3));
      n = wq.size();
      check("after_clr_nwrites", 128'(n), 128'(1));
      check("after_clr_count", 128'(count), 128'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_multi_chan_logger.md
Name: axi_multi_chan_logger

Overview:
Next-generation AXI address-channel logger. Captures handshaken address beats from NUM_CHAN independent AXI address channels (e.g. AR and AW, or several masters) into per-channel capture FIFOs. Beats are timestamped at capture, arbitrated round-robin, and written as records through one flat memory write port into an external log RAM. Supports stop-on-full and ring-buffer (wrap) modes, software clear and enable, and sticky overflow/wrap status.

Parameters:
NUM_CHAN, 2, number of monitored AXI address channels (1..8)
AXI_ADDR_BITW, 32, address width per channel
AXI_ID_BITW, 8, ID width per channel
AXI_LEN_BITW, 8, burst length width per channel
TS_BITW, 32, timestamp width
FIFO_DEPTH, 4, capture FIFO entries per channel (power of 2, >=2)
LOG_DEPTH, 4096, log RAM depth in records (power of 2)
(derived) CHAN_BITW = max(1,clog2(NUM_CHAN)); REC_BITW = CHAN_BITW+AXI_ID_BITW+AXI_LEN_BITW+AXI_ADDR_BITW+TS_BITW; MEM_DATA_BITW = 32*ceil(REC_BITW/32); MEM_ADDR_BITW = clog2(LOG_DEPTH)

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  asynchronous reset, active-high
AxiValid_SI  in  NUM_CHAN  per-channel valid
AxiReady_SI  in  NUM_CHAN  per-channel ready
AxiId_DI  in  NUM_CHAN*AXI_ID_BITW  per-channel ID, channel c at [c*AXI_ID_BITW +: AXI_ID_BITW]
AxiAddr_DI  in  NUM_CHAN*AXI_ADDR_BITW  per-channel address, same packing
AxiLen_DI  in  NUM_CHAN*AXI_LEN_BITW  per-channel length, same packing
Enable_SI  in  1  capture enable (level)
Clear_SI  in  1  synchronous clear (pulse or level)
WrapMode_SI  in  1  0 = stop on full, 1 = ring buffer
MemWrEn_SO  out  1  log RAM write strobe
MemAddr_DO  out  MEM_ADDR_BITW  log RAM record address
MemWrData_DO  out  MEM_DATA_BITW  record data
Full_SO  out  1  log full (stop mode)
Wrapped_SO  out  1  sticky: write pointer has wrapped (wrap mode)
Overflow_SO  out  1  sticky: at least one beat dropped
Count_DO  out  MEM_ADDR_BITW+1  records written since clear, saturates at LOG_DEPTH

Behaviour:
- Reset: all outputs 0; timestamp 0; FIFOs empty; write pointer 0; RR pointer 0; FSM = STOPPED.
- Timestamp: free-running, +1 per cycle, wraps all-ones->0; forced to 0 on Clear_SI.
- Capture: channel c beat captured when AxiValid_SI[c] & AxiReady_SI[c] & Enable_SI & ~Clear_SI & FSM!=FULL. The record is pushed into FIFO c with the current-cycle timestamp. All channels may capture in the same cycle.
- Drop: a capture condition met while FIFO c is full drops the beat and sets Overflow_SO. In FULL, beats are ignored and Overflow_SO is set.
- Record layout, LSB first: chan index, id, len, addr, timestamp; padding bits above REC_BITW are 0.
- Arbiter: each cycle, if FSM=RUN or (STOPPED and any FIFO non-empty), grant the first non-empty FIFO at or after the RR pointer, pop it, and set the RR pointer to grant+1 mod NUM_CHAN. At most one pop per cycle.
- Write latency: pop in cycle N -> MemWrEn_SO=1 in N+1 with MemAddr_DO = write pointer and registered data. The write pointer increments after each write.
- FSM:
  - STOPPED -> RUN when Enable_SI=1.
  - RUN -> STOPPED when Enable_SI=0; remaining FIFO contents still drain.
  - RUN/STOPPED -> FULL in stop mode when the write to address LOG_DEPTH-1 is issued.
  - FULL -> STOPPED/RUN only via Clear_SI.
- Stop mode: Full_SO=1 the cycle after the write to LOG_DEPTH-1; no further pops; FIFO contents retained.
- Wrap mode: pointer wraps LOG_DEPTH-1 -> 0; Wrapped_SO set on the first wrap; Full_SO stays 0.
- WrapMode_SI is sampled continuously. Changing it while in FULL has no effect until Clear_SI.
- Count_DO: +1 per write; saturates at LOG_DEPTH.
- Clear_SI (synchronous, priority over all else):
  - flushes FIFOs; suppresses the pending write stage (MemWrEn_SO=0 next cycle);
  - zeroes write pointer, Count_DO, Full_SO, Wrapped_SO, Overflow_SO, RR pointer, timestamp;
  - next FSM = RUN if Enable_SI else STOPPED.
- Log RAM contents are not cleared.
- Rst_RI asserted mid-operation: immediate return to reset state; an in-flight write is lost.

Optional Feature:
LOGGER_DROP_CNT_EN. Defined: adds output DropCnt_DO [15:0] counting dropped beats, several per cycle if several channels drop simultaneously. It saturates at 16'hFFFF, is zeroed by reset and Clear_SI, and Overflow_SO is unchanged. Undefined: port and counter absent; only the sticky Overflow_SO reports drops.

Test Plan:
- Single beat: NUM_CHAN=2, Enable=1, ch0 handshake id=8'h5A addr=32'h1000_0040 len=3 at timestamp 10 -> MemWrEn_SO=1 two cycles later at addr 0, record fields match, chan=0; Count_DO=1.
- Simultaneous: ch0 and ch1 beat in the same cycle with RR pointer 0 -> ch0 written at addr 0, then ch1 at addr 1, both carrying an identical timestamp; RR pointer ends at 0.
- Overflow: FIFO_DEPTH=4, ch1 handshake every cycle for 12 cycles while ch0 also handshakes every cycle -> Overflow_SO=1; with LOGGER_DROP_CNT_EN, DropCnt_DO equals 24 minus records written.
- Stop on full: LOG_DEPTH=16, WrapMode=0, 20 beats on ch0 -> exactly 16 writes (addr 0..15), Full_SO=1, Count_DO=16, no MemWrEn afterwards.
- Wrap: LOG_DEPTH=16, WrapMode=1, 20 beats -> write to addr 0 follows addr 15, Wrapped_SO=1, Full_SO=0, Count_DO=16.
- Clear mid-burst: Clear_SI asserted in the cycle after a pop -> no MemWrEn next cycle; pointer, Count, timestamp, status all 0; the next beat is written at addr 0 with timestamp restarted.
